i2s_multi_rx: RTL and testbench

I2S_MULTI_RX -- requirements
Module: i2s_multi_rx

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_clock_gen.sv | 66 ++++++
 rtl/i2s_multi_rx.sv | 102 ++++++++++
 tb/tb_i2s_multi_rx.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S receive/transmit blocks.
package i2s_pkg;

  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_SLOT     = 32;
  localparam int unsigned DEF_CHANNELS = 2;
  localparam int unsigned DEF_DIV      = 2;

  // Ceiling log2, usable in parameter expressions; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S bit/frame clock generator: divider, sck, ws, frame position and slot
// counters. Shared by the receive and transmit paths.
module i2s_clock_gen
  import i2s_pkg::*;
#(
  parameter int unsigned SLOT     = DEF_SLOT,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned DIV      = DEF_DIV,
  localparam int unsigned TOTAL   = SLOT * CHANNELS,
  localparam int unsigned PW      = clog2(TOTAL),
  localparam int unsigned BW      = clog2(SLOT),
  localparam int unsigned CW      = clog2(CHANNELS)
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          en,
  output logic          sck,
  output logic          ws,
  output logic [PW-1:0] frame_posn,
  output logic [BW-1:0] slot_bit,
  output logic [CW-1:0] slot_idx,
  output logic          rise_c
);

  localparam int unsigned DW = (DIV > 1) ? clog2(DIV) : 1;

  logic [DW-1:0] div_q;
  logic          wrap_c;
  logic          fall_c;
  logic [PW-1:0] posn_nxt_c;

  // Divider wrap marks the sck edges; the next frame position is precomputed
  // so ws can be updated from it on the same falling edge.
  always_comb begin
    wrap_c     = en && (div_q == DW'(DIV - 1));
    rise_c     = wrap_c && !sck;
    fall_c     = wrap_c && sck;
    posn_nxt_c = (frame_posn == PW'(TOTAL - 1)) ? '0 : frame_posn + PW'(1);
  end

  // Clock/frame state; disabling clears everything so restart begins at bit 0.
  always_ff @(posedge ck) begin
    if (!rst_n || !en) begin
      div_q      <= '0;
      sck        <= 1'b0;
      ws         <= 1'b0;
      frame_posn <= '0;
      slot_bit   <= '0;
      slot_idx   <= '0;
    end else begin
      div_q <= wrap_c ? '0 : div_q + DW'(1);
      if (wrap_c) sck <= ~sck;
      if (fall_c) begin
        frame_posn <= posn_nxt_c;
        ws         <= (posn_nxt_c >= PW'(TOTAL / 2));
        if (slot_bit == BW'(SLOT - 1)) begin
          slot_bit <= '0;
          slot_idx <= (slot_idx == CW'(CHANNELS - 1)) ? '0 : slot_idx + CW'(1);
        end else begin
          slot_bit <= slot_bit + BW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/i2s_multi_rx.sv
// Multi-channel I2S/TDM receiver (clock master) with valid/ready output.
// Optional feature: define I2S_RX_OVF_COUNT_EN to add the saturating
// ovf_count[7:0] dropped-sample counter.
module i2s_multi_rx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned SLOT     = DEF_SLOT,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned DIV      = DEF_DIV,
  localparam int unsigned PW      = clog2(SLOT * CHANNELS),
  localparam int unsigned CW      = clog2(CHANNELS)
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sd,
  output logic             sck,
  output logic             ws,
  output logic [PW-1:0]    frame_posn,
  output logic [WIDTH-1:0] data,
  output logic [CW-1:0]    chan,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
`ifdef I2S_RX_OVF_COUNT_EN
  ,
  output logic [7:0]       ovf_count
`endif
);

  localparam int unsigned BW = clog2(SLOT);

  logic [BW-1:0]    slot_bit;
  logic [CW-1:0]    slot_idx;
  logic             rise_c;
  logic [WIDTH-2:0] shift_q;
  logic             take_c;
  logic             done_c;
  logic [WIDTH-1:0] sample_c;

  i2s_clock_gen #(
    .SLOT     (SLOT),
    .CHANNELS (CHANNELS),
    .DIV      (DIV)
  ) u_clock_gen (
    .ck         (ck),
    .rst_n      (rst_n),
    .en         (en),
    .sck        (sck),
    .ws         (ws),
    .frame_posn (frame_posn),
    .slot_bit   (slot_bit),
    .slot_idx   (slot_idx),
    .rise_c     (rise_c)
  );

  // Bits 0..WIDTH-1 of each slot are captured; the last one completes a sample.
  always_comb begin
    take_c   = rise_c && (32'(slot_bit) < WIDTH);
    done_c   = rise_c && (32'(slot_bit) == WIDTH - 1);
    sample_c = {shift_q, sd};
  end

  // Shift register plus output holding register with drop-on-backpressure.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      shift_q <= '0;
      data    <= '0;
      chan    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (!en) begin
        shift_q <= '0;
      end else if (take_c) begin
        shift_q <= sample_c[WIDTH-2:0];
      end
      if (done_c && (!valid || ready)) begin
        data  <= sample_c;
        chan  <= slot_idx;
        valid <= 1'b1;
      end else if (done_c) begin
        overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_OVF_COUNT_EN
  // Saturating count of samples dropped while the consumer stalled.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      ovf_count <= 8'd0;
    end else if (done_c && valid && !ready && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_multi_rx.sv
// Bench for i2s_multi_rx: instance 0 uses the defaults, instance 1 uses
// CHANNELS=4, WIDTH=24, DIV=1. A frame-arithmetic model predicts outputs.
module tb_i2s_multi_rx;

  logic       ck = 1'b0;
  logic [1:0] rst_n, en, sd, ready;

  logic        sck0, ws0, valid0, ovf0;
  logic [5:0]  posn0;
  logic [15:0] data0;
  logic [0:0]  chan0;
  logic        sck1, ws1, valid1, ovf1;
  logic [6:0]  posn1;
  logic [23:0] data1;
  logic [1:0]  chan1;
`ifdef I2S_RX_OVF_COUNT_EN
  logic [7:0]  cnt0, cnt1;
`endif

  always #5 ck = ~ck;

  i2s_multi_rx #(.WIDTH(16), .SLOT(32), .CHANNELS(2), .DIV(2)) u_dut0 (
    .ck(ck), .rst_n(rst_n[0]), .en(en[0]), .sd(sd[0]), .sck(sck0), .ws(ws0),
    .frame_posn(posn0), .data(data0), .chan(chan0), .valid(valid0),
    .ready(ready[0]), .overrun(ovf0)
`ifdef I2S_RX_OVF_COUNT_EN
    , .ovf_count(cnt0)
`endif
  );

  i2s_multi_rx #(.WIDTH(24), .SLOT(32), .CHANNELS(4), .DIV(1)) u_dut1 (
    .ck(ck), .rst_n(rst_n[1]), .en(en[1]), .sd(sd[1]), .sck(sck1), .ws(ws1),
    .frame_posn(posn1), .data(data1), .chan(chan1), .valid(valid1),
    .ready(ready[1]), .overrun(ovf1)
`ifdef I2S_RX_OVF_COUNT_EN
    , .ovf_count(cnt1)
`endif
  );

  int nchk = 0;
  int nfail = 0;

  // Reference model state: m_e counts enabled clock edges since (re)start.
  int          m_e[2];
  bit          m_valid[2];
  bit          m_ovf[2];
  int unsigned m_data[2];
  int          m_chan[2];
  int          m_cnt[2];
  int unsigned words[2][8];
  bit          rand_words;
  logic [39:0] got0[$];
  logic [39:0] got1[$];

  int          obs_tim[2];
  logic [55:0] obs_str[2];

  function automatic int cfg_w(int i); return (i == 0) ? 16 : 24; endfunction
  function automatic int cfg_s(int i); return 32; endfunction
  function automatic int cfg_c(int i); return (i == 0) ? 2 : 4; endfunction
  function automatic int cfg_d(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int cfg_t(int i); return cfg_s(i) * cfg_c(i); endfunction

  // Frame position sampled at enabled edge e (sck rising), or -1.
  function automatic int samp_posn(int i, int e);
    int d;
    d = cfg_d(i);
    if (e % (2 * d) == d) return (e / (2 * d)) % cfg_t(i);
    return -1;
  endfunction

  function automatic int model_posn(int i);
    return (m_e[i] / (2 * cfg_d(i))) % cfg_t(i);
  endfunction

  // {sck, ws, frame_posn} as sck*65536 + ws*256 + posn.
  function automatic int model_tim(int i);
    int p;
    p = model_posn(i);
    return ((m_e[i] / cfg_d(i)) % 2) * 65536 + ((p >= cfg_t(i) / 2) ? 256 : 0) + p;
  endfunction

  function automatic logic [55:0] model_str(int i);
    int c;
    c = 0;
`ifdef I2S_RX_OVF_COUNT_EN
    c = m_cnt[i];
`endif
    return {6'd0, m_valid[i], m_ovf[i], 8'(c), 8'(m_chan[i]), 32'(m_data[i])};
  endfunction

  function automatic bit next_done(int i);
    int p;
    if (!en[i] || !rst_n[i]) return 1'b0;
    p = samp_posn(i, m_e[i] + 1);
    return (p >= 0) && (p % cfg_s(i) == cfg_w(i) - 1);
  endfunction

  // One clock: drive sd, advance the model at the edge, sample DUT #1 later.
  task automatic cycle();
    int p[2];
    int b, sl, w, dc;
    int unsigned dd;
    bit done;
    logic [7:0] c0, c1;
    for (int i = 0; i < 2; i++) begin
      p[i] = -1;
      sd[i] = 1'($urandom);
      w = cfg_w(i);
      if (en[i] && rst_n[i]) begin
        p[i] = samp_posn(i, m_e[i] + 1);
        if (p[i] >= 0) begin
          b  = p[i] % cfg_s(i);
          sl = p[i] / cfg_s(i);
          if (b == 0 && rand_words) words[i][sl] = $urandom & ((32'd1 << w) - 32'd1);
          if (b < w) sd[i] = 1'(words[i][sl] >> (w - 1 - b));
        end
      end
    end
    if (rst_n[0] && valid0 === 1'b1 && ready[0]) got0.push_back({8'(chan0), 32'(data0)});
    if (rst_n[1] && valid1 === 1'b1 && ready[1]) got1.push_back({8'(chan1), 32'(data1)});
    @(posedge ck);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        m_e[i] = 0; m_valid[i] = 0; m_ovf[i] = 0; m_data[i] = 0; m_chan[i] = 0; m_cnt[i] = 0;
      end else begin
        done = 0; dd = 0; dc = 0;
        if (en[i]) begin
          m_e[i]++;
          if (p[i] >= 0 && p[i] % cfg_s(i) == cfg_w(i) - 1) begin
            done = 1;
            dc = p[i] / cfg_s(i);
            dd = words[i][dc];
          end
        end else begin
          m_e[i] = 0;
        end
        if (done && (!m_valid[i] || ready[i])) begin
          m_valid[i] = 1; m_data[i] = dd; m_chan[i] = dc;
        end else if (done) begin
          m_ovf[i] = 1;
          if (m_cnt[i] < 255) m_cnt[i]++;
        end else if (m_valid[i] && ready[i]) begin
          m_valid[i] = 0;
        end
      end
    end
    #1;
    c0 = 8'd0; c1 = 8'd0;
`ifdef I2S_RX_OVF_COUNT_EN
    c0 = cnt0; c1 = cnt1;
`endif
    obs_tim[0] = (sck0 ? 65536 : 0) + (ws0 ? 256 : 0) + int'(posn0);
    obs_tim[1] = (sck1 ? 65536 : 0) + (ws1 ? 256 : 0) + int'(posn1);
    obs_str[0] = {6'd0, valid0, ovf0, c0, 8'(chan0), 32'(data0)};
    obs_str[1] = {6'd0, valid1, ovf1, c1, 8'(chan1), 32'(data1)};
  endtask

  task automatic do_reset();
    rst_n = 2'b00;
    cycle();
    rst_n = 2'b11;
  endtask

  task automatic test_reset();
    rst_n = 2'b00; en = 2'b11; ready = 2'b11; rand_words = 1;
    repeat (3) cycle();
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (obs_tim[i] !== 0) begin
        nfail++; $display("FAIL reset_timing[%0d]: got %h want 0", i, obs_tim[i]);
      end
      nchk++;
      if (obs_str[i] !== 56'd0) begin
        nfail++; $display("FAIL reset_stream[%0d]: got %h want 0", i, obs_str[i]);
      end
    end
  endtask

  task automatic test_timing();
    rst_n = 2'b11; en = 2'b00; ready = 2'b11; rand_words = 1;
    cycle();
    en = 2'b11;
    for (int n = 1; n <= 300; n++) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs_tim[i] !== model_tim(i)) begin
          nfail++; $display("FAIL timing[%0d] n=%0d: got %h want %h", i, n, obs_tim[i], model_tim(i));
        end
        if (n == cfg_d(i)) begin
          nchk++;
          if (obs_tim[i] !== 65536) begin
            nfail++; $display("FAIL first_rise[%0d]: got %h want 10000", i, obs_tim[i]);
          end
        end
        if (n == 256) begin
          nchk++;
          if (obs_tim[i] !== 0) begin
            nfail++; $display("FAIL frame_wrap[%0d]: got %h want 0", i, obs_tim[i]);
          end
        end
      end
      if (n == 128) begin
        nchk++;
        if (obs_tim[0] !== 288) begin
          nfail++; $display("FAIL ws_rise[0]: got %h want 120", obs_tim[0]);
        end
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    en = 2'b11; ready = 2'b11; rand_words = 0;
    words[0][0] = 32'h8234; words[0][1] = 32'h8235;
    for (int k = 0; k < 4; k++) words[1][k] = 32'hA00001 + 32'(k);
    got0.delete(); got1.delete();
    repeat (560) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs_str[i] !== model_str(i)) begin
          nfail++; $display("FAIL stream[%0d] @%0t: got %h want %h", i, $time, obs_str[i], model_str(i));
        end
      end
    end
    nchk++;
    if (got0.size() < 4) begin
      nfail++; $display("FAIL stream_count[0]: got %0d want >=4", got0.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        nchk++;
        if (got0[k] !== {8'(k % 2), 32'h8234 + 32'(k % 2)}) begin
          nfail++; $display("FAIL stream_xfer[0][%0d]: got %h", k, got0[k]);
        end
      end
    end
    nchk++;
    if (got1.size() < 8) begin
      nfail++; $display("FAIL stream_count[1]: got %0d want >=8", got1.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        nchk++;
        if (got1[k] !== {8'(k % 4), 32'hA00001 + 32'(k % 4)}) begin
          nfail++; $display("FAIL stream_xfer[1][%0d]: got %h", k, got1[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    en = 2'b11; ready = 2'b00; rand_words = 1;
    n = 0;
    while (!(m_ovf[0] && m_ovf[1]) && n < 1000) begin
      cycle();
      n++;
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs_str[i] !== model_str(i)) begin
          nfail++; $display("FAIL bp_stream[%0d] @%0t: got %h want %h", i, $time, obs_str[i], model_str(i));
        end
      end
    end
    nchk++;
    if (n >= 1000) begin
      nfail++; $display("FAIL bp_timeout: got %0d cycles want <1000", n);
    end
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (obs_str[i][49:48] !== 2'b11 || obs_str[i][39:32] !== 8'd0 || obs_str[i][31:0] !== words[i][0]) begin
        nfail++; $display("FAIL bp_hold[%0d]: got %h want valid/ovf=1 chan 0 data %h", i, obs_str[i], words[i][0]);
      end
    end
`ifdef I2S_RX_OVF_COUNT_EN
    nchk++;
    if (obs_str[0][47:40] !== 8'd1) begin
      nfail++; $display("FAIL bp_count[0]: got %0d want 1", obs_str[0][47:40]);
    end
    repeat (33000) cycle();
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (obs_str[i][47:40] !== 8'd255 || obs_str[i] !== model_str(i)) begin
        nfail++; $display("FAIL bp_saturate[%0d]: got %h want %h", i, obs_str[i], model_str(i));
      end
    end
`endif
    ready = 2'b11;
    repeat (20) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs_str[i] !== model_str(i) || obs_str[i][48] !== 1'b1) begin
          nfail++; $display("FAIL bp_drain[%0d] @%0t: got %h want %h", i, $time, obs_str[i], model_str(i));
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    bit hit[2];
    bit pulsed[2];
    int n;
    do_reset();
    en = 2'b11; ready = 2'b00; rand_words = 1;
    hit[0] = 0; hit[1] = 0;
    n = 0;
    while (!(hit[0] && hit[1]) && n < 1000) begin
      for (int i = 0; i < 2; i++) begin
        pulsed[i] = m_valid[i] && !hit[i] && next_done(i);
        ready[i]  = pulsed[i];
      end
      cycle();
      n++;
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs_str[i] !== model_str(i)) begin
          nfail++; $display("FAIL same_stream[%0d] @%0t: got %h want %h", i, $time, obs_str[i], model_str(i));
        end
        if (pulsed[i]) begin
          hit[i] = 1;
          nchk++;
          if (obs_str[i][49:48] !== 2'b10 || obs_str[i][39:32] !== 8'd1 || obs_str[i][31:0] !== words[i][1]) begin
            nfail++; $display("FAIL same_cycle[%0d]: got %h want valid=1 ovf=0 chan 1 data %h", i, obs_str[i], words[i][1]);
          end
        end
      end
    end
    nchk++;
    if (n >= 1000) begin
      nfail++; $display("FAIL same_timeout: got %0d cycles want <1000", n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    en = 2'b11; ready = 2'b00; rand_words = 1;
    n = 0;
    while (model_posn(0) != 40 && n < 1000) begin
      cycle();
      n++;
    end
    nchk++;
    if (obs_str[0][49] !== 1'b1 || int'(posn0) !== 40) begin
      nfail++; $display("FAIL mid_setup: got valid %b posn %0d want 1 40", obs_str[0][49], posn0);
    end
    rst_n = 2'b00;
    cycle();
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (obs_tim[i] !== 0 || obs_str[i] !== 56'd0) begin
        nfail++; $display("FAIL mid_reset[%0d]: got %h/%h want 0/0", i, obs_tim[i], obs_str[i]);
      end
    end
    rst_n = 2'b11; ready = 2'b11;
    got0.delete(); got1.delete();
    repeat (300) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs_str[i] !== model_str(i)) begin
          nfail++; $display("FAIL mid_stream[%0d] @%0t: got %h want %h", i, $time, obs_str[i], model_str(i));
        end
      end
    end
    nchk++;
    if (got0.size() < 1 || got1.size() < 1) begin
      nfail++; $display("FAIL mid_first: got %0d/%0d transfers want >=1", got0.size(), got1.size());
    end else if (got0[0][39:32] !== 8'd0 || got1[0][39:32] !== 8'd0) begin
      nfail++; $display("FAIL mid_first: got chan %0d/%0d want 0/0", got0[0][39:32], got1[0][39:32]);
    end
  endtask

  task automatic test_enable();
    int n;
    do_reset();
    en = 2'b11; ready = 2'b00; rand_words = 1;
    n = 0;
    while (!(m_valid[0] && m_valid[1]) && n < 1000) begin
      cycle();
      n++;
    end
    repeat (7) cycle();
    en = 2'b00;
    repeat (5) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs_tim[i] !== 0 || obs_str[i][49] !== 1'b1) begin
          nfail++; $display("FAIL en_off[%0d]: got tim %h valid %b want 0 1", i, obs_tim[i], obs_str[i][49]);
        end
      end
    end
    ready = 2'b11;
    cycle();
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if (obs_str[i][49] !== 1'b0) begin
        nfail++; $display("FAIL en_off_xfer[%0d]: got valid %b want 0", i, obs_str[i][49]);
      end
    end
    en = 2'b11;
    for (int k = 1; k <= 300; k++) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs_tim[i] !== model_tim(i) || obs_str[i] !== model_str(i)) begin
          nfail++; $display("FAIL en_restart[%0d] k=%0d: got %h/%h want %h/%h", i, k, obs_tim[i], obs_str[i], model_tim(i), model_str(i));
        end
        if (k == cfg_d(i)) begin
          nchk++;
          if (obs_tim[i] !== 65536) begin
            nfail++; $display("FAIL en_first_rise[%0d]: got %h want 10000", i, obs_tim[i]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 2'b11; rand_words = 1;
    repeat (4000) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom % 250 == 0) en[i] = ~en[i];
        ready[i] = 1'($urandom % 3 != 0);
        rst_n[i] = 1'($urandom % 1500 != 0);
      end
      cycle();
      for (int i = 0; i < 2; i++) begin
        nchk++;
        if (obs_tim[i] !== model_tim(i) || obs_str[i] !== model_str(i)) begin
          nfail++; $display("FAIL random[%0d] @%0t: got %h/%h want %h/%h", i, $time, obs_tim[i], obs_str[i], model_tim(i), model_str(i));
        end
      end
    end
  endtask

  initial begin
    rst_n = 2'b00; en = 2'b00; ready = 2'b00; sd = 2'b00; rand_words = 1;
    for (int i = 0; i < 2; i++) begin
      m_e[i] = 0; m_valid[i] = 0; m_ovf[i] = 0; m_data[i] = 0; m_chan[i] = 0; m_cnt[i] = 0;
      for (int k = 0; k < 8; k++) words[i][k] = 0;
      obs_tim[i] = 0; obs_str[i] = '0;
    end
    test_reset();
    test_timing();
    test_stream();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    test_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
